// File: rtl/ams_pwm_pkg.sv
`default_nettype none
// ============================================================================
// ams_pwm_pkg : register map, CTRL field positions and bit-reverse helper
// Revision    : 1.0
// ============================================================================
package ams_pwm_pkg;

    localparam logic [19:0] VAL_BASE = 20'h00000;
    localparam logic [19:0] CTRL     = 20'h00040;
    localparam logic [19:0] COMMIT   = 20'h00044;
    localparam logic [19:0] STATUS   = 20'h00048;

    localparam int CTRL_EN_LSB     = 0;
    localparam int CTRL_SRC_LSB    = 16;
    localparam int CTRL_AUTO_BIT   = 31;
    localparam int STATUS_PEND_BIT = 8;

    localparam int DSP_W = 14;

    typedef enum logic [2:0] {
        REG_NONE   = 3'd0,
        REG_VAL    = 3'd1,
        REG_CTRL   = 3'd2,
        REG_COMMIT = 3'd3,
        REG_STATUS = 3'd4
    } reg_sel_e;

    // Reverses the low w bits of v; bits above w return 0.
    function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
        logic [15:0] r;
        r = {<<{v}};
        return r >> (16 - w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ams_pwm_channel.sv
`default_nettype none
// ============================================================================
// ams_pwm_channel : one dithered PWM channel (active value, compare, output reg)
// Revision        : 1.0
// ============================================================================
module ams_pwm_channel
    import ams_pwm_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int DITH_BITS = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [PWM_BITS-1:0]           pcnt_i,
    input  logic [DITH_BITS-1:0]          dcnt_i,
    input  logic                          load_i,
    input  logic                          enable_i,
    input  logic [PWM_BITS+DITH_BITS-1:0] value_i,
    output logic                          pwm_o
);

    localparam int VW = PWM_BITS + DITH_BITS;

    logic [VW-1:0]        active_q;
    logic                 pwm_q;
    logic                 pwm_d;
    logic [PWM_BITS-1:0]  w_duty;
    logic [DITH_BITS-1:0] w_frac;
    logic [DITH_BITS-1:0] w_rev;
    logic                 w_ext;
    logic [PWM_BITS:0]    w_thresh;

    assign w_duty = active_q[VW-1:DITH_BITS];
    assign w_frac = active_q[DITH_BITS-1:0];

    // Bit-reversed period index spreads the extra cycles evenly across the dither cycle.
    assign w_rev    = DITH_BITS'(bitrev(16'(dcnt_i), DITH_BITS));
    assign w_ext    = (w_rev < w_frac);
    assign w_thresh = {1'b0, w_duty} + {{PWM_BITS{1'b0}}, w_ext};
    assign pwm_d    = enable_i & ({1'b0, pcnt_i} < w_thresh);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            if (load_i) begin
                active_q <= value_i;
            end
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule
`default_nettype wire

// File: rtl/ams_pwm_dac_bank.sv
`default_nettype none
// ============================================================================
// ams_pwm_dac_bank : NCH-channel dithered PWM DAC with shadowed bus registers
// Revision         : 1.0
// ============================================================================
module ams_pwm_dac_bank
    import ams_pwm_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int PWM_BITS  = 8,
    parameter int DITH_BITS = 4
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [NCH*DSP_W-1:0]   dsp_i,
    output logic [NCH-1:0]         pwm_o,
    output logic                   period_o,
    input  logic [31:0]            sys_addr,
    input  logic [31:0]            sys_wdata,
    input  logic [3:0]             sys_sel,
    input  logic                   sys_wen,
    input  logic                   sys_ren,
    output logic [31:0]            sys_rdata,
    output logic                   sys_err,
    output logic                   sys_ack
);

    localparam int VW = PWM_BITS + DITH_BITS;
    localparam logic [PWM_BITS-1:0] PCNT_MAX = '1;

    logic [PWM_BITS-1:0]        pcnt_q;
    logic [DITH_BITS-1:0]       dcnt_q;
    logic                       period_q;
    logic [NCH-1:0][VW-1:0]     shadow_q;
    logic [NCH-1:0]             en_q;
    logic [NCH-1:0]             src_q;
    logic                       auto_q;
    logic                       pending_q;
    logic                       pending_d;
    logic                       ack_q;
    logic [31:0]                rdata_q;
    logic [31:0]                rdata_d;

    logic [19:0]                w_addr;
    logic [3:0]                 w_idx;
    reg_sel_e                   w_sel;
    logic [NCH-1:0]             w_val_we;
    logic                       w_boundary;
    logic                       w_load;
    logic                       w_unused;

    assign w_addr     = sys_addr[19:0];
    assign w_idx      = w_addr[5:2];
    assign w_boundary = (pcnt_q == PCNT_MAX);
    assign w_load     = w_boundary & (auto_q | pending_q);
    assign w_unused   = ^{sys_sel, sys_addr[31:20], sys_wdata};

    always_comb begin
        w_sel = REG_NONE;
        if ((w_addr[19:6] == VAL_BASE[19:6]) && (w_addr[1:0] == 2'b00) && ({1'b0, w_idx} < 5'(NCH))) begin
            w_sel = REG_VAL;
        end else if (w_addr == CTRL) begin
            w_sel = REG_CTRL;
        end else if (w_addr == COMMIT) begin
            w_sel = REG_COMMIT;
        end else if (w_addr == STATUS) begin
            w_sel = REG_STATUS;
        end
    end

    always_comb begin
        w_val_we = '0;
        for (int k = 0; k < NCH; k++) begin
            w_val_we[k] = sys_wen && (w_sel == REG_VAL) && (w_idx == 4'(k));
        end
    end

    // A commit landing on the boundary survives the clear and is honoured one period later.
    always_comb begin
        pending_d = pending_q;
        if (w_boundary) begin
            pending_d = 1'b0;
        end
        if (sys_wen && (w_sel == REG_COMMIT)) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        rdata_d = '0;
        case (w_sel)
            REG_VAL: begin
                for (int k = 0; k < NCH; k++) begin
                    if (w_idx == 4'(k)) begin
                        rdata_d[VW-1:0] = shadow_q[k];
                    end
                end
            end
            REG_CTRL: begin
                rdata_d[CTRL_EN_LSB +: NCH]  = en_q;
                rdata_d[CTRL_SRC_LSB +: NCH] = src_q;
                rdata_d[CTRL_AUTO_BIT]       = auto_q;
            end
            REG_COMMIT: begin
                rdata_d[0] = pending_q;
            end
            REG_STATUS: begin
                rdata_d[DITH_BITS-1:0]   = dcnt_q;
                rdata_d[STATUS_PEND_BIT] = pending_q;
            end
            default: begin
                rdata_d = '0;
            end
        endcase
        if (!sys_ren) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pcnt_q    <= '0;
            dcnt_q    <= '0;
            period_q  <= 1'b0;
            shadow_q  <= '0;
            en_q      <= '0;
            src_q     <= '0;
            auto_q    <= 1'b0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            pcnt_q   <= pcnt_q + 1'b1;
            period_q <= w_boundary;
            if (w_boundary) begin
                dcnt_q <= dcnt_q + 1'b1;
            end
            for (int k = 0; k < NCH; k++) begin
                if (w_val_we[k]) begin
                    shadow_q[k] <= sys_wdata[VW-1:0];
                end
            end
            if (sys_wen && (w_sel == REG_CTRL)) begin
                en_q   <= sys_wdata[CTRL_EN_LSB +: NCH];
                src_q  <= sys_wdata[CTRL_SRC_LSB +: NCH];
                auto_q <= sys_wdata[CTRL_AUTO_BIT];
            end
            pending_q <= pending_d;
            ack_q     <= sys_wen | sys_ren;
            rdata_q   <= rdata_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DSP_W-1:0] w_dsp_off;
        logic [VW-1:0]    w_value;

        // Offset-binary conversion maps the most negative sample to 0.
        assign w_dsp_off = {~dsp_i[k*DSP_W + DSP_W-1], dsp_i[k*DSP_W +: DSP_W-1]};
        assign w_value   = src_q[k] ? w_dsp_off[DSP_W-1 -: VW] : shadow_q[k];

        ams_pwm_channel #(
            .PWM_BITS  (PWM_BITS),
            .DITH_BITS (DITH_BITS)
        ) u_ch (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .pcnt_i   (pcnt_q),
            .dcnt_i   (dcnt_q),
            .load_i   (w_load),
            .enable_i (en_q[k]),
            .value_i  (w_value),
            .pwm_o    (pwm_o[k])
        );
    end

    assign period_o  = period_q;
    assign sys_ack   = ack_q;
    assign sys_rdata = rdata_q;
    assign sys_err   = 1'b0;

endmodule
`default_nettype wire
